scm_fifo_ctrl: RTL
==================

Name: scm_fifo_ctrl

Overview:
- Initiator-side controller that turns the latch-based SCM register file (1 byte-enabled write port, N read ports, 1-cycle registered read address) into a valid/ready FIFO.
- Drives the SCM write port and one SCM read port.
- Enforces the SCM write-commit latency before reads.
- Prefetches into a 2-entry output skid buffer so a steady stream sustains 1 word/cycle.
- Sits between a streaming producer and consumer wherever a latch SCM replaces a flop FIFO.

Parameters:
- ADDR_WIDTH, 5, SCM address width; storage depth DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- NUM_BYTE, DATA_WIDTH/8, byte lanes driven on the SCM write byte-enable.

Ports:
- clk  in  1  clock (the SCM uses the same clock)
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all pointers and buffers
- in_valid_i  in  1  producer word valid
- in_ready_o  out  1  FIFO can accept
- in_data_i  in  DATA_WIDTH  producer word
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer accepts
- out_data_o  out  DATA_WIDTH  output word
- count_o  out  ADDR_WIDTH+1  words held (SCM plus skid buffer)
- scm_we_o  out  1  SCM WriteEnable
- scm_waddr_o  out  ADDR_WIDTH  SCM WriteAddr
- scm_wdata_o  out  DATA_WIDTH  SCM WriteData
- scm_wbe_o  out  NUM_BYTE  SCM WriteBE, all ones whenever scm_we_o is 1, otherwise 0
- scm_re_o  out  1  SCM ReadEnable (one read port)
- scm_raddr_o  out  ADDR_WIDTH  SCM ReadAddr
- scm_rdata_i  in  DATA_WIDTH  SCM ReadData; valid the cycle after scm_re_o

Behaviour:
- Reset state: all pointers and counters 0; skid buffer empty; in_ready_o=1; out_valid_o=0; out_data_o=0; count_o=0; scm_we_o=0; scm_re_o=0.

Write path:
- Push occurs on in_valid_i & in_ready_o.
- On a push, the same cycle drives scm_we_o=1, scm_waddr_o=wptr, scm_wdata_o=in_data_i.
- wptr increments modulo DEPTH.
- in_ready_o = (SCM entries, written but not yet read-issued) < DEPTH. This is combinational from registered state only.

Commit rule:
- A word written in cycle t is read-eligible from cycle t+1 onward.
- The latch is transparent in the high phase of t+1, so issuing a read of that address in cycle t is forbidden.
- Track this with a registered "committed" count that lags the write by one cycle.

Read path:
- scm_re_o=1 with scm_raddr_o=rptr when both hold:
  - committed count > 0
  - (skid occupancy + reads in flight) < 2
- rptr increments modulo DEPTH on each read.
- scm_rdata_i is captured into the skid buffer the following cycle.
- At most 1 read is in flight.

Skid buffer:
- 2 entries; head drives out_valid_o and out_data_o from registers.
- Pop occurs on out_valid_o & out_ready_i.
- out_data_o must hold stable while out_valid_o=1 and out_ready_i=0.

Latency and throughput:
- Push accepted in cycle t gives out_valid_o=1 in cycle t+3 (write t, read t+1, capture t+2, visible t+3).
- Steady state is 1 push and 1 pop per cycle.

Boundary conditions:
- Full (DEPTH words in SCM): in_ready_o=0. A read issued in the same cycle frees a slot, visible next cycle.
- A simultaneous push and pop when full is not accepted that cycle, because in_ready_o is registered-based.
- Pointer wrap from DEPTH-1 to 0 is seamless.
- count_o maximum is DEPTH+2; it saturates at 2**(ADDR_WIDTH+1)-1 if that bound is exceeded.

Flush:
- flush_i=1 for one cycle clears pointers, the skid buffer, and the in-flight read flag, with priority over any push or pop in that cycle.
- scm_we_o and scm_re_o are forced to 0 in the flush cycle.
- A read returning after a flush is discarded.

Reset mid-operation: rst_n low immediately returns every register to its reset state. SCM contents are don't-care.

Optional Feature:
- Macro: SCM_FIFO_BYPASS_EN.
- Defined: if the SCM is empty, no read is in flight, no write is pending commit, and the skid buffer has a free slot, a pushed word goes directly into the skid buffer and is not written to the SCM (scm_we_o=0). Push at cycle t gives out_valid_o in cycle t+1.
- Not defined: every word passes through the SCM with the 3-cycle latency above; no bypass logic is synthesised.

Test Plan:
- Reset, then a single push of 0xDEADBEEF at cycle 0 with out_ready_i=1 -> scm_we_o=1 and scm_wbe_o=0xF in cycle 0; scm_re_o=1 in cycle 1; out_valid_o=1 with 0xDEADBEEF in cycle 3 (cycle 1 with SCM_FIFO_BYPASS_EN) -> count_o returns to 0.
- Back-to-back push of 0..99 with out_ready_i=1 -> output is 0..99 in order, no bubbles after the initial latency, and no read is issued to an address in its write cycle.
- out_ready_i=0, push 34 words at ADDR_WIDTH=5 -> in_ready_o drops after 32+2 words; count_o=34; out_data_o is stable at word 0 -> release out_ready_i and all 34 words drain in order.
- Random valid/ready over 3 wraps of DEPTH -> scoreboard matches; wptr and rptr wrap 31 to 0 without loss.
- Fill 10 words, assert flush_i during a pending read -> next cycle out_valid_o=0, count_o=0, the stale read is discarded; a following push of 0x5 emerges as the next output.
- Assert rst_n low mid-stream -> all outputs return to their reset values asynchronously; the FIFO operates normally after release.

Source files
------------

// File: rtl/scm_fifo_ctrl.sv
// Valid/ready FIFO controller built on a latch-based SCM register file with a 2-entry skid buffer.
// Define SCM_FIFO_BYPASS_EN to let words skip the SCM when the whole pipeline is empty.
module scm_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  scm_we_o,
    output logic [ADDR_WIDTH-1:0] scm_waddr_o,
    output logic [DATA_WIDTH-1:0] scm_wdata_o,
    output logic [NUM_BYTE-1:0]   scm_wbe_o,
    output logic                  scm_re_o,
    output logic [ADDR_WIDTH-1:0] scm_raddr_o,
    input  logic [DATA_WIDTH-1:0] scm_rdata_i
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned CW1   = CW + 1;

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         scm_cnt_q, scm_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            skid_cnt_q, skid_cnt_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid0_d, skid1_q, skid1_d;

    logic                  push, pop, wr, rd, cap, bypass;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [CW1-1:0]        cnt_sum;

    // scm_cnt_q only reflects writes of earlier cycles, so it doubles as the committed count:
    // a word written this cycle can never be read-issued before the next one.
    assign in_ready_o  = scm_cnt_q < CW'(DEPTH);
    assign out_valid_o = skid_cnt_q != 2'd0;
    assign out_data_o  = skid0_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

`ifdef SCM_FIFO_BYPASS_EN
    assign bypass   = push & (scm_cnt_q == '0) & ~inflight_q & ((skid_cnt_q != 2'd2) | pop);
    assign cap_data = bypass ? in_data_i : scm_rdata_i;
`else
    assign bypass   = 1'b0;
    assign cap_data = scm_rdata_i;
`endif

    // Occupancy is counted after this cycle's pop so a streaming consumer sees no bubbles.
    assign occ = 3'(skid_cnt_q) + 3'(inflight_q);
    assign wr  = push & ~bypass;
    assign rd  = ~flush_i & (scm_cnt_q != '0) & (occ < (3'd2 + 3'(pop)));
    assign cap = inflight_q | bypass;

    assign scm_we_o    = wr;
    assign scm_waddr_o = wptr_q;
    assign scm_wdata_o = in_data_i;
    assign scm_wbe_o   = {NUM_BYTE{wr}};
    assign scm_re_o    = rd;
    assign scm_raddr_o = rptr_q;

    assign cnt_sum = CW1'(scm_cnt_q) + CW1'(skid_cnt_q) + CW1'(inflight_q);
    assign count_o = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];

    always_comb begin
        wptr_d     = wptr_q + ADDR_WIDTH'(wr);
        rptr_d     = rptr_q + ADDR_WIDTH'(rd);
        scm_cnt_d  = scm_cnt_q + CW'(wr) - CW'(rd);
        inflight_d = rd;
        skid_cnt_d = skid_cnt_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        if (flush_i) begin
            wptr_d     = '0;
            rptr_d     = '0;
            scm_cnt_d  = '0;
            skid_cnt_d = 2'd0;
            skid0_d    = '0;
            skid1_d    = '0;
        end else begin
            case ({pop, cap})
                2'b10: begin
                    skid0_d    = skid1_q;
                    skid_cnt_d = skid_cnt_q - 2'd1;
                end
                2'b01: begin
                    if (skid_cnt_q == 2'd0) skid0_d = cap_data;
                    else                    skid1_d = cap_data;
                    skid_cnt_d = skid_cnt_q + 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid0_d = cap_data;
                    end else begin
                        skid0_d = skid1_q;
                        skid1_d = cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            scm_cnt_q  <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
            skid1_q    <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            scm_cnt_q  <= scm_cnt_d;
            inflight_q <= inflight_d;
            skid_cnt_q <= skid_cnt_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
        end
    end

endmodule
